parking_space_allocator: RTL and testbench

- Downstream of the token/confirm register manager in the smart-parking datapath.
- Consumes the level-held P_register_enable / Q_register_enable selects and assigns a physical slot in the P bank (after-hours) or Q bank (regular).
- Records each slot's entry time and, on exit, reports parked duration and frees the slot.
- Feeds the display/fee stage with grant, reject and exit results.

---
 rtl/parking_space_allocator_pkg.sv | 24 ++
 rtl/parking_space_allocator_if.sv | 39 +++
 rtl/parking_space_allocator_slot_bank.sv | 90 +++++++++
 rtl/parking_space_allocator.sv | 164 ++++++++++++++++
 tb/tb_parking_space_allocator.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/parking_space_allocator_pkg.sv
// Shared definitions for the parking space allocator: bank encodings, time width,
// after-hours threshold and the request-serving state type.
package parking_space_allocator_pkg;

    localparam logic BANK_P = 1'b0;
    localparam logic BANK_Q = 1'b1;

    localparam int TIME_W = 8;

    // Upper time nibble at which the upstream manager routes cars to the P bank
    localparam logic [3:0] AFTER_HOURS_NIBBLE = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SERVE  = 2'd1,
        ST_PEND_P = 2'd2,
        ST_PEND_Q = 2'd3
    } serve_state_t;

    function automatic logic is_after_hours(input logic [TIME_W-1:0] t);
        return t[7:4] == AFTER_HOURS_NIBBLE;
    endfunction

endpackage

// File: rtl/parking_space_allocator_if.sv
// Request/result bus between the register manager, the allocator and the fee stage.
interface parking_space_allocator_if #(parameter int TIME_W = 8);

    logic              P_register_enable;
    logic              Q_register_enable;
    logic [TIME_W-1:0] time_data;
    logic              exit_request;
    logic              exit_bank;
    logic [2:0]        exit_slot;

    logic              grant_valid;
    logic              grant_bank;
    logic [2:0]        grant_slot;
    logic              reject;
    logic              exit_valid;
    logic [TIME_W-1:0] exit_duration;
    logic              exit_error;
    logic [3:0]        P_count;
    logic [3:0]        Q_count;
    logic              P_full;
    logic              Q_full;

    modport master (
        output P_register_enable, Q_register_enable, time_data,
               exit_request, exit_bank, exit_slot,
        input  grant_valid, grant_bank, grant_slot, reject,
               exit_valid, exit_duration, exit_error,
               P_count, Q_count, P_full, Q_full
    );

    modport slave (
        input  P_register_enable, Q_register_enable, time_data,
               exit_request, exit_bank, exit_slot,
        output grant_valid, grant_bank, grant_slot, reject,
               exit_valid, exit_duration, exit_error,
               P_count, Q_count, P_full, Q_full
    );

endinterface

// File: rtl/parking_space_allocator_slot_bank.sv
// One bank of parking slots: occupancy, entry times, lowest-free-slot search,
// occupancy count and parked-duration calculation.
module parking_space_allocator_slot_bank #(
    parameter int N_SLOTS = 4,
    parameter int TIME_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alloc_req,
    input  logic [TIME_W-1:0] time_now,
    input  logic              exit_req,
    input  logic [2:0]        exit_slot,
    output logic              alloc_ok,
    output logic [2:0]        alloc_slot,
    output logic              exit_ok,
    output logic [TIME_W-1:0] exit_duration,
    output logic [3:0]        count,
    output logic              full
);

    logic [N_SLOTS-1:0] occ_q, occ_d;
    logic [TIME_W-1:0]  entry_q [N_SLOTS];
    logic [TIME_W-1:0]  entry_d [N_SLOTS];
    logic [3:0]         count_q, count_d;
    logic               full_q, full_d;
    logic               alloc_do, exit_do;

    // Descending scan so the lowest free index is the one left standing
    always_comb begin
        alloc_ok   = 1'b0;
        alloc_slot = 3'd0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!occ_q[i]) begin
                alloc_ok   = 1'b1;
                alloc_slot = 3'(i);
            end
        end
    end

    // Indices at or beyond N_SLOTS match no entry and therefore report not-ok
    always_comb begin
        exit_ok       = 1'b0;
        exit_duration = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (exit_slot == 3'(i)) begin
                exit_ok       = occ_q[i];
                exit_duration = time_now - entry_q[i];
            end
        end
    end

    assign alloc_do = alloc_req & alloc_ok;
    assign exit_do  = exit_req & exit_ok;

    always_comb begin
        occ_d   = occ_q;
        entry_d = entry_q;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (alloc_do && alloc_slot == 3'(i)) begin
                occ_d[i]   = 1'b1;
                entry_d[i] = time_now;
            end
            if (exit_do && exit_slot == 3'(i)) begin
                occ_d[i] = 1'b0;
            end
        end
        count_d = count_q + 4'(alloc_do) - 4'(exit_do);
        full_d  = (count_d == 4'(N_SLOTS));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            occ_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            for (int i = 0; i < N_SLOTS; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            occ_q   <= occ_d;
            entry_q <= entry_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    assign count = count_q;
    assign full  = full_q;

endmodule

// File: rtl/parking_space_allocator.sv
// Assigns P/Q bank slots on rising edges of the manager's enables, serving one
// request per cycle (P before Q), and releases slots with a parked-duration report.
module parking_space_allocator #(
    parameter int P_SLOTS = 4,
    parameter int Q_SLOTS = 8,
    parameter int TIME_W  = 8
) (
    input logic                     clock,
    input logic                     reset,
    parking_space_allocator_if.slave bus
);

    import parking_space_allocator_pkg::*;

    serve_state_t      state_q, state_d;
    logic              p_prev_q, q_prev_q;
    logic              p_rise, q_rise;
    logic              serve_p, serve_q;

    logic              p_alloc_ok, q_alloc_ok;
    logic [2:0]        p_free_slot, q_free_slot;
    logic              p_exit_req, q_exit_req;
    logic              p_exit_ok, q_exit_ok;
    logic [TIME_W-1:0] p_duration, q_duration;

    logic              grant_valid_q, grant_valid_d;
    logic              grant_bank_q, grant_bank_d;
    logic [2:0]        grant_slot_q, grant_slot_d;
    logic              reject_q, reject_d;
    logic              exit_valid_q, exit_valid_d;
    logic [TIME_W-1:0] exit_duration_q, exit_duration_d;
    logic              exit_error_q, exit_error_d;

    assign p_rise = bus.P_register_enable & ~p_prev_q;
    assign q_rise = bus.Q_register_enable & ~q_prev_q;

    // A held-over request always goes before fresh edges; a fresh edge that
    // loses arbitration becomes the (single) held-over request
    always_comb begin
        serve_p = 1'b0;
        serve_q = 1'b0;
        state_d = ST_IDLE;
        case (state_q)
            ST_PEND_Q: begin
                serve_q = 1'b1;
                state_d = p_rise ? ST_PEND_P : ST_SERVE;
            end
            ST_PEND_P: begin
                serve_p = 1'b1;
                state_d = q_rise ? ST_PEND_Q : ST_SERVE;
            end
            default: begin
                if (p_rise) begin
                    serve_p = 1'b1;
                    state_d = q_rise ? ST_PEND_Q : ST_SERVE;
                end else if (q_rise) begin
                    serve_q = 1'b1;
                    state_d = ST_SERVE;
                end
            end
        endcase
    end

    always_comb begin
        grant_valid_d = 1'b0;
        grant_bank_d  = BANK_P;
        grant_slot_d  = 3'd0;
        reject_d      = 1'b0;
        if (serve_p) begin
            grant_bank_d  = BANK_P;
            grant_valid_d = p_alloc_ok;
            reject_d      = ~p_alloc_ok;
            grant_slot_d  = p_alloc_ok ? p_free_slot : 3'd0;
        end else if (serve_q) begin
            grant_bank_d  = BANK_Q;
            grant_valid_d = q_alloc_ok;
            reject_d      = ~q_alloc_ok;
            grant_slot_d  = q_alloc_ok ? q_free_slot : 3'd0;
        end
    end

    assign p_exit_req = bus.exit_request & (bus.exit_bank == BANK_P);
    assign q_exit_req = bus.exit_request & (bus.exit_bank == BANK_Q);

    always_comb begin
        exit_valid_d    = (p_exit_req & p_exit_ok) | (q_exit_req & q_exit_ok);
        exit_error_d    = bus.exit_request & ~exit_valid_d;
        exit_duration_d = '0;
        if (exit_valid_d) begin
            exit_duration_d = (bus.exit_bank == BANK_Q) ? q_duration : p_duration;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            p_prev_q        <= 1'b0;
            q_prev_q        <= 1'b0;
            grant_valid_q   <= 1'b0;
            grant_bank_q    <= 1'b0;
            grant_slot_q    <= 3'd0;
            reject_q        <= 1'b0;
            exit_valid_q    <= 1'b0;
            exit_duration_q <= '0;
            exit_error_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            p_prev_q        <= bus.P_register_enable;
            q_prev_q        <= bus.Q_register_enable;
            grant_valid_q   <= grant_valid_d;
            grant_bank_q    <= grant_bank_d;
            grant_slot_q    <= grant_slot_d;
            reject_q        <= reject_d;
            exit_valid_q    <= exit_valid_d;
            exit_duration_q <= exit_duration_d;
            exit_error_q    <= exit_error_d;
        end
    end

    parking_space_allocator_slot_bank #(
        .N_SLOTS(P_SLOTS),
        .TIME_W (TIME_W)
    ) u_p_bank (
        .clock        (clock),
        .reset        (reset),
        .alloc_req    (serve_p),
        .time_now     (bus.time_data),
        .exit_req     (p_exit_req),
        .exit_slot    (bus.exit_slot),
        .alloc_ok     (p_alloc_ok),
        .alloc_slot   (p_free_slot),
        .exit_ok      (p_exit_ok),
        .exit_duration(p_duration),
        .count        (bus.P_count),
        .full         (bus.P_full)
    );

    parking_space_allocator_slot_bank #(
        .N_SLOTS(Q_SLOTS),
        .TIME_W (TIME_W)
    ) u_q_bank (
        .clock        (clock),
        .reset        (reset),
        .alloc_req    (serve_q),
        .time_now     (bus.time_data),
        .exit_req     (q_exit_req),
        .exit_slot    (bus.exit_slot),
        .alloc_ok     (q_alloc_ok),
        .alloc_slot   (q_free_slot),
        .exit_ok      (q_exit_ok),
        .exit_duration(q_duration),
        .count        (bus.Q_count),
        .full         (bus.Q_full)
    );

    assign bus.grant_valid   = grant_valid_q;
    assign bus.grant_bank    = grant_bank_q;
    assign bus.grant_slot    = grant_slot_q;
    assign bus.reject        = reject_q;
    assign bus.exit_valid    = exit_valid_q;
    assign bus.exit_duration = exit_duration_q;
    assign bus.exit_error    = exit_error_q;

endmodule

// File: tb/tb_parking_space_allocator.sv
// Directed bench for the parking space allocator with hand-computed expectations
// (P_SLOTS = 4, Q_SLOTS = 8, TIME_W = 8).
module tb_parking_space_allocator;

    import parking_space_allocator_pkg::*;

    logic clock;
    logic reset;
    int   compare_count;
    int   mismatch_count;

    parking_space_allocator_if #(.TIME_W(8)) bus ();

    parking_space_allocator #(
        .P_SLOTS(4),
        .Q_SLOTS(8),
        .TIME_W (8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read there too
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic p_en, input logic q_en, input logic [7:0] t);
        bus.P_register_enable = p_en;
        bus.Q_register_enable = q_en;
        bus.time_data         = t;
        tick();
    endtask

    task automatic dropEnables();
        bus.P_register_enable = 1'b0;
        bus.Q_register_enable = 1'b0;
        tick();
    endtask

    task automatic requestExit(input logic bank, input logic [2:0] slot, input logic [7:0] t);
        bus.exit_request = 1'b1;
        bus.exit_bank    = bank;
        bus.exit_slot    = slot;
        bus.time_data    = t;
        tick();
        bus.exit_request = 1'b0;
    endtask

    task automatic doReset();
        bus.P_register_enable = 1'b0;
        bus.Q_register_enable = 1'b0;
        bus.exit_request      = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic checkGrant(input string tag, input logic valid, input logic bank,
                              input logic [2:0] slot, input logic rej);
        checkOutput({tag, "_valid"}, 32'(bus.grant_valid), 32'(valid));
        checkOutput({tag, "_bank"},  32'(bus.grant_bank),  32'(bank));
        checkOutput({tag, "_slot"},  32'(bus.grant_slot),  32'(slot));
        checkOutput({tag, "_reject"}, 32'(bus.reject),     32'(rej));
    endtask

    initial begin
        logic       route_bank;
        logic [7:0] t;
        compare_count  = 0;
        mismatch_count = 0;
        bus.P_register_enable = 1'b0;
        bus.Q_register_enable = 1'b0;
        bus.time_data         = 8'h00;
        bus.exit_request      = 1'b0;
        bus.exit_bank         = 1'b0;
        bus.exit_slot         = 3'd0;
        reset                 = 1'b0;

        // Reset state
        tick();
        checkGrant("rst", 1'b0, 1'b0, 3'd0, 1'b0);
        checkOutput("rst_p_count", 32'(bus.P_count), 0);
        checkOutput("rst_q_count", 32'(bus.Q_count), 0);
        checkOutput("rst_p_full", 32'(bus.P_full), 0);
        checkOutput("rst_q_full", 32'(bus.Q_full), 0);
        checkOutput("rst_exit_valid", 32'(bus.exit_valid), 0);
        checkOutput("rst_exit_error", 32'(bus.exit_error), 0);
        checkOutput("rst_exit_dur", 32'(bus.exit_duration), 0);
        reset = 1'b1;

        // P held high for 5 cycles gives a single grant
        applyStimulus(1'b1, 1'b0, 8'h20);
        checkGrant("hold_first", 1'b1, BANK_P, 3'd0, 1'b0);
        checkOutput("hold_p_count", 32'(bus.P_count), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("hold_no_regrant", 32'(bus.grant_valid), 0);
        end
        dropEnables();
        checkOutput("hold_p_count_after", 32'(bus.P_count), 1);

        // Fill P bank, then one more edge is rejected
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(8'h30 + i));
            checkGrant("fill_p", 1'b1, BANK_P, 3'(i), 1'b0);
            dropEnables();
        end
        checkOutput("fill_p_count", 32'(bus.P_count), 4);
        checkOutput("fill_p_full", 32'(bus.P_full), 1);
        applyStimulus(1'b1, 1'b0, 8'h40);
        checkGrant("p_reject", 1'b0, BANK_P, 3'd0, 1'b1);
        dropEnables();
        checkOutput("p_reject_pulse_gone", 32'(bus.reject), 0);
        checkOutput("p_reject_count", 32'(bus.P_count), 4);

        // Simultaneous P and Q edges: P first, Q one cycle later
        doReset();
        applyStimulus(1'b1, 1'b1, 8'h50);
        checkGrant("both_p", 1'b1, BANK_P, 3'd0, 1'b0);
        checkOutput("both_q_count_n1", 32'(bus.Q_count), 0);
        tick();
        checkGrant("both_q", 1'b1, BANK_Q, 3'd0, 1'b0);
        checkOutput("both_q_count_n2", 32'(bus.Q_count), 1);
        tick();
        checkOutput("both_done", 32'(bus.grant_valid), 0);
        dropEnables();

        // Reset during a pending Q request discards it
        doReset();
        applyStimulus(1'b1, 1'b1, 8'h60);
        checkGrant("abort_p", 1'b1, BANK_P, 3'd0, 1'b0);
        bus.P_register_enable = 1'b0;
        bus.Q_register_enable = 1'b0;
        reset = 1'b0;
        #2;
        checkOutput("abort_async_clear", 32'(bus.grant_valid), 0);
        checkOutput("abort_async_count", 32'(bus.P_count), 0);
        reset = 1'b1;
        tick();
        checkOutput("abort_no_q_grant", 32'(bus.grant_valid), 0);
        tick();
        checkOutput("abort_q_count", 32'(bus.Q_count), 0);

        // Wrap-around duration: enter at 0xFA, exit at 0x04
        doReset();
        applyStimulus(1'b0, 1'b1, 8'hFA);
        checkGrant("wrap_grant", 1'b1, BANK_Q, 3'd0, 1'b0);
        dropEnables();
        requestExit(BANK_Q, 3'd0, 8'h04);
        checkOutput("wrap_exit_valid", 32'(bus.exit_valid), 1);
        checkOutput("wrap_exit_dur", 32'(bus.exit_duration), 10);
        checkOutput("wrap_exit_error", 32'(bus.exit_error), 0);
        checkOutput("wrap_q_count", 32'(bus.Q_count), 0);
        tick();
        checkOutput("wrap_pulse_gone", 32'(bus.exit_valid), 0);

        // Exit errors: free Q slot, out-of-range P slot
        applyStimulus(1'b1, 1'b0, 8'h70);
        dropEnables();
        requestExit(BANK_Q, 3'd3, 8'h75);
        checkOutput("err_q_free", 32'(bus.exit_error), 1);
        checkOutput("err_q_free_valid", 32'(bus.exit_valid), 0);
        checkOutput("err_q_count", 32'(bus.Q_count), 0);
        requestExit(BANK_P, 3'd5, 8'h76);
        checkOutput("err_p_range", 32'(bus.exit_error), 1);
        checkOutput("err_p_range_valid", 32'(bus.exit_valid), 0);
        checkOutput("err_p_count", 32'(bus.P_count), 1);
        requestExit(BANK_P, 3'd0, 8'h78);
        checkOutput("p_exit_valid", 32'(bus.exit_valid), 1);
        checkOutput("p_exit_dur", 32'(bus.exit_duration), 8);
        checkOutput("p_exit_count", 32'(bus.P_count), 0);

        // Full Q bank: exit of slot 2 and a new Q edge in the same cycle
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(8'h10 + i));
            checkOutput("fill_q_slot", 32'(bus.grant_slot), i);
            dropEnables();
        end
        checkOutput("fill_q_full", 32'(bus.Q_full), 1);
        bus.exit_request      = 1'b1;
        bus.exit_bank         = BANK_Q;
        bus.exit_slot         = 3'd2;
        applyStimulus(1'b0, 1'b1, 8'h30);
        bus.exit_request      = 1'b0;
        checkOutput("same_exit_valid", 32'(bus.exit_valid), 1);
        checkOutput("same_exit_dur", 32'(bus.exit_duration), 8'h1E);
        checkGrant("same_reject", 1'b0, BANK_Q, 3'd0, 1'b1);
        checkOutput("same_q_count", 32'(bus.Q_count), 7);
        checkOutput("same_q_full", 32'(bus.Q_full), 0);
        dropEnables();
        applyStimulus(1'b0, 1'b1, 8'h31);
        checkGrant("reuse_slot2", 1'b1, BANK_Q, 3'd2, 1'b0);
        checkOutput("reuse_q_count", 32'(bus.Q_count), 8);
        checkOutput("reuse_q_full", 32'(bus.Q_full), 1);
        dropEnables();

        // Upstream routing model: after-hours time stamps go to the P bank
        doReset();
        t = 8'hF3;
        route_bank = is_after_hours(t) ? BANK_P : BANK_Q;
        applyStimulus(route_bank == BANK_P, route_bank == BANK_Q, t);
        checkGrant("route_after_hours", 1'b1, BANK_P, 3'd0, 1'b0);
        dropEnables();
        t = 8'h43;
        route_bank = is_after_hours(t) ? BANK_P : BANK_Q;
        applyStimulus(route_bank == BANK_P, route_bank == BANK_Q, t);
        checkGrant("route_regular", 1'b1, BANK_Q, 3'd0, 1'b0);
        dropEnables();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
